uart_tx_periph: RTL and testbench
=================================

# uart_tx_periph

Memory-mapped 8N1 UART transmitter with a TX FIFO, placed on the RS5 data bus beside the RAM, RTC and PLIC. It consumes the core's store traffic through the same enable/write-enable/address/data slave interface, and its registered read data feeds the platform read mux. It serialises queued bytes onto `tx_o` and raises a level interrupt toward the PLIC when the queue has drained.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries. Must be a power of two, ≥2.
- `DEFAULT_DIV`, 16'd867: reset value of DIV. Bit period is DIV+1 clocks.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `reset` input, 1 bit: **asynchronous, active-high** reset.
- `en_i` input, 1 bit: slave select for this cycle.
- `we_i` input, 4 bits: byte write enables. Any nonzero value is a write; zero is a read.
- `addr_i` input, 4 bits: register offset. Only 0x0, 0x4, 0x8 and 0xC are decoded.
- `data_i` input, 32 bits: write data.
- `data_o` output, 32 bits: registered read data.
- `tx_o` output, 1 bit: serial line, idle high.
- `irq_o` output, 1 bit: level interrupt to the PLIC.

## Operation
Register map:
- 0x0 TXDATA (W): pushes `data_i[7:0]`. If the FIFO is full, the byte is dropped and OVF is set. Reads return 0.
- 0x4 STATUS (R): bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVF (sticky), bits[7+:N] count, where N = $clog2(FIFO_DEPTH+1). A write with `data_i[3]`=1 clears OVF.
- 0x8 DIV (RW): bits[15:0]. DIV=0 is legal and gives 1 clock per bit.
- 0xC CTRL (RW): bit0 TXEN (reset 1), bit1 IRQEN (reset 0).
- Unmapped offsets: writes are ignored, reads return 0.

Reads and bus rules:
- `data_o` loads only when `en_i` is high and `we_i`==0. Otherwise it holds its value.
- Write data is taken from the register's full field regardless of which byte enables are set.

FIFO:
- Circular buffer with wrapping read/write pointers and an explicit count (range 0..FIFO_DEPTH).
- FULL is count==FIFO_DEPTH. EMPTY is count==0.
- If a push to a full FIFO coincides with a pop in the same cycle, the push is still dropped. FULL is evaluated before the pop.

FSM states: IDLE, START, DATA, STOP.
- IDLE → START when TXEN=1 and the FIFO is not empty. On this edge, pop the head into the shift register, latch DIV into the bit timer reload, and clear the bit counter.
- START: `tx_o`=0 for DIV+1 clocks, then go to DATA.
- DATA: send 8 bits LSB-first, each for DIV+1 clocks, then go to STOP.
- STOP: `tx_o`=1 for DIV+1 clocks. Then:
  - if TXEN=1 and the FIFO is not empty, go to START, popping on that same edge (back-to-back frames with no idle gap);
  - otherwise go to IDLE.

Other rules:
- Writing DIV mid-frame takes effect only from the next frame.
- Clearing TXEN mid-frame lets the current frame finish; no further frames start.
- `irq_o` = IRQEN & EMPTY & ~BUSY, as a combinational function of registered state.

Reset values:
- `tx_o`=1, `data_o`=0, `irq_o`=0.
- FSM in IDLE; FIFO empty with both pointers 0; OVF=0; DIV=DEFAULT_DIV; TXEN=1; IRQEN=0.

Reset asserted mid-frame aborts the frame immediately: `tx_o` returns to 1 asynchronously and all queued bytes are discarded.

## Timing
- Read latency is 1 cycle: a read sampled at edge E produces `data_o` valid after E.
- A TXDATA push sampled at edge E0 makes the FIFO non-empty after E0.
- From IDLE, the FSM pops at E1 and `tx_o` falls after E1. There is 1 cycle from the write edge to the start bit.
- Frame length is exactly 10·(DIV+1) clocks. Back-to-back frames have no extra cycles between them.
- STATUS reflects the FIFO count after the edge on which a push or pop occurred.
- `irq_o` rises the cycle after the FSM enters IDLE with the FIFO empty, provided IRQEN=1.

## Test plan
- Reset check: assert `reset` with no clock running → `tx_o`=1, `data_o`=0, `irq_o`=0. After release, a read of 0x8 returns 0x363 and a read of 0x4 returns EMPTY=1.
- Single frame: DIV=3, write 0xA5 to 0x0 → start bit begins 1 cycle after the write. `tx_o` pattern is 0,1,0,1,0,0,1,0,1,1, each value held 4 clocks, 40 clocks in total, then BUSY=0.
- Back-to-back frames: DIV=0, push 0x00 then 0xFF → 20 contiguous bit periods with no idle cycle between the stop bit and the next start bit.
- Overflow: TXEN=0, push 9 bytes → count=8, FULL=1, OVF=1, and the 9th byte is lost. Write 0x8 to 0x4 clears OVF. Set TXEN=1 → exactly 8 frames in FIFO order.
- Interrupt: IRQEN=1, DIV=1, push 0x55 → `irq_o`=0 while BUSY, then `irq_o`=1 one cycle after STOP completes. Clearing IRQEN drops `irq_o` the next cycle.
- Mid-frame disturbances:
  - Write DIV=7 in the middle of a frame running at DIV=1 → the current frame keeps 2-clock bits and the next frame uses 8-clock bits.
  - Assert `reset` mid-DATA → `tx_o`=1 immediately and count=0 after release.

Source files
------------

// File: rtl/uart_tx_periph_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_periph_if
// Description : Slave bus bundle for the memory-mapped UART transmitter.
//               Carries the core's enable / byte-write-enable / address /
//               write-data signals and returns the registered read data.
// Ports       : en_i    - slave select for this cycle
//               we_i    - byte write enables (nonzero = write, zero = read)
//               addr_i  - register offset
//               data_i  - write data
//               data_o  - registered read data
// Modports    : master - drives the request, samples data_o
//               slave  - samples the request, drives data_o
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_periph_if;
  logic        en_i;
  logic [3:0]  we_i;
  logic [3:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output en_i,
    output we_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  en_i,
    input  we_i,
    input  addr_i,
    input  data_i,
    output data_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_periph
// Description : Memory-mapped 8N1 UART transmitter with a TX FIFO. Bytes
//               written to TXDATA are queued and serialised LSB-first onto
//               tx_o, one start bit, eight data bits and one stop bit, each
//               lasting DIV+1 clocks. A level interrupt is raised when the
//               queue has drained and the transmitter is idle.
// Parameters  : FIFO_DEPTH  - TX FIFO entries (power of two, >= 2)
//               DEFAULT_DIV - reset value of the DIV register
// Ports       : clk   - single clock, rising edge
//               reset - asynchronous active-high reset
//               bus   - slave bus (en_i, we_i, addr_i, data_i, data_o)
//               tx_o  - serial line, idle high
//               irq_o - level interrupt: IRQEN & EMPTY & ~BUSY
// Registers   : 0x0 TXDATA (W)  push data_i[7:0]; reads return 0
//               0x4 STATUS (R)  {count[7+:N], OVF, BUSY, EMPTY, FULL};
//                               writing data_i[3]=1 clears OVF
//               0x8 DIV    (RW) bits[15:0]
//               0xC CTRL   (RW) bit0 TXEN, bit1 IRQEN
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_periph #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  wire             clk,
  input  wire             reset,
  uart_tx_periph_if.slave bus,
  output logic            tx_o,
  output logic            irq_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_DIV    = 4'h8;
  localparam logic [3:0] ADDR_CTRL   = 4'hC;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  // Bus decode
  logic             wr_req;
  logic             rd_req;
  logic             push_req;
  logic             push_ok;
  logic             push_drop;

  // FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;

  // Control / status registers
  logic [15:0]      div_q;
  logic             txen;
  logic             irqen;
  logic             ovf;
  logic [31:0]      status_word;
  logic [31:0]      read_word;
  logic [31:0]      data_q;

  // Transmit FSM and datapath
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             frame_load;
  logic             busy;
  logic [7:0]       shift_q;
  logic [15:0]      bit_reload;
  logic [15:0]      bit_timer;
  logic [2:0]       bit_cnt;
  logic             bit_done;

  // Upper write-data bits have no destination in any register.
  logic             unused_data_hi;
  assign unused_data_hi = ^bus.data_i[31:16];

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  assign wr_req    = bus.en_i && (bus.we_i != 4'h0);
  assign rd_req    = bus.en_i && (bus.we_i == 4'h0);
  assign push_req  = wr_req && (bus.addr_i == ADDR_TXDATA);
  // FULL is judged before any pop on the same edge, so a push into a full
  // FIFO is dropped even when the transmitter frees a slot simultaneously.
  assign push_ok   = push_req && !fifo_full;
  assign push_drop = push_req && fifo_full;

  // --------------------------------------------------------------------------
  // TX FIFO: circular buffer, pointers wrap naturally (power-of-two depth)
  // --------------------------------------------------------------------------
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];

  // Storage needs no reset: only entries below fifo_count are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus.data_i[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (frame_load) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, frame_load})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control / status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= DEFAULT_DIV;
      txen  <= 1'b1;
      irqen <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (wr_req && (bus.addr_i == ADDR_DIV)) begin
        div_q <= bus.data_i[15:0];
      end
      if (wr_req && (bus.addr_i == ADDR_CTRL)) begin
        txen  <= bus.data_i[0];
        irqen <= bus.data_i[1];
      end
      if (push_drop) begin
        ovf <= 1'b1;
      end else if (wr_req && (bus.addr_i == ADDR_STATUS) && bus.data_i[3]) begin
        ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    status_word              = '0;
    status_word[0]           = fifo_full;
    status_word[1]           = fifo_empty;
    status_word[2]           = busy;
    status_word[3]           = ovf;
    status_word[7 +: CNT_W]  = fifo_count;
  end

  always_comb begin
    read_word = '0;
    case (bus.addr_i)
      ADDR_STATUS: read_word = status_word;
      ADDR_DIV:    read_word = {16'h0000, div_q};
      ADDR_CTRL:   read_word = {30'h0, irqen, txen};
      default:     read_word = '0;
    endcase
  end

  // Read data holds between reads so the platform mux sees a stable value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (rd_req) begin
      data_q <= read_word;
    end
  end

  assign bus.data_o = data_q;

  // --------------------------------------------------------------------------
  // Transmit FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM: next-state logic
  // frame_load marks the edge that pops the FIFO head and starts a frame,
  // either from IDLE or straight out of a finishing STOP bit so that
  // back-to-back frames have no idle gap.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    frame_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (txen && !fifo_empty) begin
          state_next = ST_START;
          frame_load = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done && (bit_cnt == 3'd7)) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (txen && !fifo_empty) begin
            state_next = ST_START;
            frame_load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transmit FSM: outputs
  // tx_o is decoded from registered state, so an asynchronous reset forces
  // the line high immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    tx_o = 1'b1;
    busy = 1'b1;
    case (state)
      ST_IDLE:  busy = 1'b0;
      ST_START: tx_o = 1'b0;
      ST_DATA:  tx_o = shift_q[0];
      default:  tx_o = 1'b1;
    endcase
  end

  assign irq_o = irqen && fifo_empty && !busy;

  // --------------------------------------------------------------------------
  // Bit timer and shift register
  // The timer counts down from the reload value; a bit ends on the cycle it
  // reads zero, giving DIV+1 clocks per bit. DIV is copied into bit_reload
  // only when a frame starts, so DIV writes mid-frame apply to the next frame.
  // --------------------------------------------------------------------------
  assign bit_done = (bit_timer == 16'h0000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      bit_reload <= '0;
      bit_timer  <= '0;
      bit_cnt    <= '0;
    end else if (frame_load) begin
      shift_q    <= fifo_head;
      bit_reload <= div_q;
      bit_timer  <= div_q;
      bit_cnt    <= '0;
    end else if (state != ST_IDLE) begin
      if (bit_done) begin
        bit_timer <= bit_reload;
        if (state == ST_DATA) begin
          shift_q <= {1'b0, shift_q[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        bit_timer <= bit_timer - 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_periph
// Description : Self-checking bench for uart_tx_periph. A queue-based model
//               of the register file, FIFO contents and expected serial line
//               is checked against tx_o, irq_o and data_o every cycle, and
//               directed scenarios pin the model with literal waveforms.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_periph;

  localparam int DEPTH = 8;

  logic clk     = 1'b0;
  logic clk_run = 1'b0;
  logic reset   = 1'b1;
  logic tx;
  logic irq;

  int tests = 0;
  int fails = 0;

  uart_tx_periph_if bus ();

  uart_tx_periph #(
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd867)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx_o  (tx),
    .irq_o (irq)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: register values, FIFO as a byte queue, and the serial
  // line as a queue of per-clock levels still to be shown.
  // --------------------------------------------------------------------------
  logic [7:0]  fq[$];
  logic        line[$];
  logic [15:0] m_div;
  logic        m_txen;
  logic        m_irqen;
  logic        m_ovf;
  logic [31:0] m_rd;

  task automatic model_reset();
    fq.delete();
    line.delete();
    m_div   = 16'd867;
    m_txen  = 1'b1;
    m_irqen = 1'b0;
    m_ovf   = 1'b0;
    m_rd    = 32'h0;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(fq.size()) << 7;
    if (fq.size() == DEPTH) s[0] = 1'b1;
    if (fq.size() == 0)     s[1] = 1'b1;
    if (line.size() > 0)    s[2] = 1'b1;
    if (m_ovf)              s[3] = 1'b1;
    return s;
  endfunction

  task automatic model_step();
    logic       full_pre;
    logic [7:0] b;
    full_pre = (fq.size() == DEPTH);
    if (bus.en_i && bus.we_i == 4'h0) begin
      case (bus.addr_i)
        4'h4:    m_rd = model_status();
        4'h8:    m_rd = {16'h0, m_div};
        4'hC:    m_rd = {30'h0, m_irqen, m_txen};
        default: m_rd = 32'h0;
      endcase
    end
    if (line.size() > 0) void'(line.pop_front());
    if (line.size() == 0 && m_txen && fq.size() > 0) begin
      b = fq.pop_front();
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c <= int'(m_div); c++) begin
          line.push_back(k == 0 ? 1'b0 : (k == 9 ? 1'b1 : b[k-1]));
        end
      end
    end
    if (bus.en_i && bus.we_i != 4'h0) begin
      case (bus.addr_i)
        4'h0: if (full_pre) m_ovf = 1'b1; else fq.push_back(bus.data_i[7:0]);
        4'h4: if (bus.data_i[3]) m_ovf = 1'b0;
        4'h8: m_div = bus.data_i[15:0];
        4'hC: begin m_txen = bus.data_i[0]; m_irqen = bus.data_i[1]; end
        default: ;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (reset) model_reset();
      else       model_step();
      #1;
      check("tx_line",   tx,         (line.size() > 0) ? line[0] : 1'b1);
      check("irq_level", irq,        m_irqen && fq.size() == 0 && line.size() == 0);
      check("read_data", bus.data_o, m_rd);
    end
  end

  // --------------------------------------------------------------------------
  // Bus helpers (inputs change on the falling edge)
  // --------------------------------------------------------------------------
  task automatic bus_idle();
    bus.en_i   = 1'b0;
    bus.we_i   = 4'h0;
    bus.addr_i = 4'h0;
    bus.data_i = 32'h0;
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.en_i   = e;
    bus.we_i   = w;
    bus.addr_i = a;
    bus.data_i = d;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    drive(1'b1, 4'hF, a, d);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    drive(1'b1, 4'h0, a, 32'h0);
    @(posedge clk);
    #1;
    check(name, bus.data_o, exp);
    @(negedge clk);
    bus_idle();
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    logic [79:0] cap;
    logic [79:0] cap2;
    bus_idle();

    // Reset with no clock running
    reset = 1'b1;
    #20;
    check("reset_tx",   tx,         1);
    check("reset_data", bus.data_o, 0);
    check("reset_irq",  irq,        0);
    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_read(4'h8, 32'h363, "div_reset");
    bus_read(4'h4, 32'h2,   "status_reset");
    bus_read(4'hC, 32'h1,   "ctrl_reset");
    bus_read(4'h0, 32'h0,   "txdata_reads_zero");
    bus_read(4'h2, 32'h0,   "unmapped_reads_zero");

    // Single frame, DIV=3 written through one byte lane only
    drive(1'b1, 4'h1, 4'h8, 32'h3);
    drive(1'b1, 4'hF, 4'h0, 32'hA5);
    @(posedge clk); #1;
    bus_idle();
    check("tx_high_on_push_edge", tx, 1);
    cap = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cap = {cap[78:0], tx};
    end
    check("frame_a5_div3", cap, 80'h0F0F00F0FF);
    @(posedge clk);
    bus_read(4'h4, 32'h2, "status_idle_after_frame");

    // Back-to-back frames, DIV=0
    bus_write(4'h8, 32'h0);
    drive(1'b1, 4'hF, 4'h0, 32'h00);
    drive(1'b1, 4'hF, 4'h0, 32'hFF);
    cap = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus_idle();
      cap = {cap[78:0], tx};
    end
    check("back_to_back", cap, 80'h005FF);

    // Overflow with transmitter disabled
    bus_write(4'hC, 32'h0);
    for (int i = 0; i < 9; i++) drive(1'b1, 4'hF, 4'h0, 32'h10 + 32'(i));
    @(negedge clk);
    bus_idle();
    bus_read(4'h4, 32'h409, "status_full_ovf");
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, 32'h401, "status_ovf_cleared");
    bus_write(4'hC, 32'h1);
    repeat (85) @(posedge clk);
    bus_read(4'h4, 32'h2, "status_drained");

    // Interrupt
    bus_write(4'h8, 32'h1);
    bus_write(4'hC, 32'h3);
    @(posedge clk); #1;
    check("irq_idle_empty", irq, 1);
    drive(1'b1, 4'hF, 4'h0, 32'h55);
    @(posedge clk); #1;
    bus_idle();
    check("irq_low_queued", irq, 0);
    cap = '0;
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk); #1;
      if (i <= 20) cap = {cap[78:0], tx};
      if (i == 20) check("irq_low_in_stop", irq, 0);
      if (i == 21) check("irq_high_after_stop", irq, 1);
    end
    check("frame_55_div1", cap, 80'h33333);
    drive(1'b1, 4'hF, 4'hC, 32'h1);
    @(posedge clk); #1;
    bus_idle();
    check("irq_drop_on_irqen_clear", irq, 0);

    // DIV change mid-frame: current frame keeps DIV=1, next uses DIV=7
    drive(1'b1, 4'hF, 4'h0, 32'h55);
    drive(1'b1, 4'hF, 4'h0, 32'h00);
    cap  = '0;
    cap2 = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus.en_i = 1'b1; bus.we_i = 4'h1; bus.addr_i = 4'h8; bus.data_i = 32'h7;
      end
      if (i == 1) bus_idle();
      if (i < 20) cap  = {cap[78:0], tx};
      else        cap2 = {cap2[78:0], tx};
    end
    check("frame_keeps_old_div", cap,  80'h33333);
    check("frame_uses_new_div",  cap2, 80'hFF);

    // Reset asserted mid-DATA
    drive(1'b1, 4'hF, 4'h0, 32'h00);
    drive(1'b1, 4'hF, 4'h0, 32'h11);
    drive(1'b1, 4'hF, 4'h0, 32'h22);
    @(negedge clk);
    bus_idle();
    repeat (12) @(posedge clk);
    #2;
    check("tx_low_mid_data", tx, 0);
    reset = 1'b1;
    #1;
    check("tx_async_reset", tx, 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_read(4'h4, 32'h2,   "status_after_reset");
    bus_read(4'h8, 32'h363, "div_after_reset");

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
